// File: rtl/life_gen_seq.sv
// Generation sequencer for the Life array: scans an X-by-Y cell array, debounces the step and
// run keys, and latches a per-frame update enable from manual steps or a free-running divider.
module life_gen_seq #(
  parameter int unsigned X        = 8,
  parameter int unsigned Y        = 8,
  parameter int unsigned LOG2X    = 3,
  parameter int unsigned LOG2Y    = 3,
  parameter int unsigned DEB_BITS = 4,
  parameter int unsigned RATE_W   = 8,
  parameter int unsigned GEN_W    = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   key_nxt_i,
  input  logic                   key_run_i,
  input  logic [RATE_W-1:0]      rate_i,
  output logic [LOG2X+LOG2Y-1:0] cnt_o,
  output logic [LOG2X-1:0]       x_o,
  output logic [LOG2Y-1:0]       y_o,
  output logic                   frame_last_o,
  output logic                   nxt_bit_o,
  output logic                   running_o,
  output logic [GEN_W-1:0]       gen_o
);

  localparam int unsigned CW = LOG2X + LOG2Y;
  localparam logic [CW-1:0]    CntLast  = CW'(X * Y - 1);
  localparam logic [CW-1:0]    CntLatch = CW'(X * Y - 2);
  localparam logic [LOG2X-1:0] XLast    = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] YLast    = LOG2Y'(Y - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LOG2X-1:0] x_q, x_d;
  logic [LOG2Y-1:0] y_q, y_d;
  logic             nxt_q, nxt_d;
  logic             run_q, run_d;
  logic             pend_q, pend_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [RATE_W-1:0] fdiv_q, fdiv_d;

  // Index 0 is the step key, index 1 the run key.
  logic [1:0]                s1_q, s2_q, deb_q, deb_d;
  logic [1:0][DEB_BITS-1:0]  dc_q, dc_d;
  logic [1:0]                flip, fall;
  logic [1:0]                key;

  logic latch, auto, load;

  assign key   = {key_run_i, key_nxt_i};
  assign latch = (cnt_q == CntLatch);

  always_comb begin
    deb_d = deb_q;
    dc_d  = '0;
    flip  = '0;
    fall  = '0;
    for (int k = 0; k < 2; k++) begin
      flip[k] = (s2_q[k] != deb_q[k]) && (&dc_q[k]);
      fall[k] = flip[k] && deb_q[k];
      if (flip[k]) begin
        deb_d[k] = s2_q[k];
      end else if (s2_q[k] != deb_q[k]) begin
        dc_d[k] = dc_q[k] + 1'b1;
      end
    end
  end

  always_comb begin
    auto = run_q && latch && (fdiv_q == rate_i);
    load = pend_q | auto;

    cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    x_d   = (x_q == XLast) ? '0 : x_q + 1'b1;
    y_d   = y_q;
    if (x_q == XLast) y_d = (y_q == YLast) ? '0 : y_q + 1'b1;

    // A release on the latch edge survives to be consumed at the following latch point.
    pend_d = fall[0] ? 1'b1 : (latch ? 1'b0 : pend_q);
    run_d  = run_q ^ fall[1];

    fdiv_d = fdiv_q;
    if (!run_q)     fdiv_d = '0;
    else if (latch) fdiv_d = auto ? '0 : fdiv_q + 1'b1;

    nxt_d = latch ? load : nxt_q;
    gen_d = gen_q + GEN_W'(latch && load);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      nxt_q  <= 1'b0;
      run_q  <= 1'b0;
      pend_q <= 1'b0;
      gen_q  <= '0;
      fdiv_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      deb_q  <= '0;
      dc_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      x_q    <= x_d;
      y_q    <= y_d;
      nxt_q  <= nxt_d;
      run_q  <= run_d;
      pend_q <= pend_d;
      gen_q  <= gen_d;
      fdiv_q <= fdiv_d;
      s1_q   <= key;
      s2_q   <= s1_q;
      deb_q  <= deb_d;
      dc_q   <= dc_d;
    end
  end

  assign cnt_o        = cnt_q;
  assign x_o          = x_q;
  assign y_o          = y_q;
  assign frame_last_o = (cnt_q == CntLast);
  assign nxt_bit_o    = nxt_q;
  assign running_o    = run_q;
  assign gen_o        = gen_q;

endmodule

// File: tb/tb_life_gen_seq.sv
// Directed bench for life_gen_seq on a 5x3 array with a 4-cycle debounce window.
module tb_life_gen_seq;

  logic        clk;
  logic        reset;
  logic        key_nxt;
  logic        key_run;
  logic [7:0]  rate;
  logic [4:0]  cnt;
  logic [2:0]  x;
  logic [1:0]  y;
  logic        frame_last;
  logic        nxt_bit;
  logic        running;
  logic [15:0] gen;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_cnt = 0;
  int exp_gen = 0;
  int m;

  life_gen_seq #(
    .X(5), .Y(3), .LOG2X(3), .LOG2Y(2), .DEB_BITS(2), .RATE_W(8), .GEN_W(16)
  ) dut (
    .clk_i(clk), .reset_i(reset), .key_nxt_i(key_nxt), .key_run_i(key_run), .rate_i(rate),
    .cnt_o(cnt), .x_o(x), .y_o(y), .frame_last_o(frame_last), .nxt_bit_o(nxt_bit),
    .running_o(running), .gen_o(gen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Advance one edge, track the expected scan index, then sample 1ns later.
  task automatic tick();
    @(posedge clk);
    if (reset) exp_cnt = 0;
    else       exp_cnt = (exp_cnt + 1) % 15;
    #1;
  endtask

  task automatic wait_cnt(input int c);
    for (int i = 0; i < 20 && exp_cnt != c; i++) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cnt"}, 32'(cnt), 0);
    chk({tag, "_xy"}, 32'({x, y}), 0);
    chk({tag, "_nxt"}, 32'(nxt_bit), 0);
    chk({tag, "_run"}, 32'(running), 0);
    chk({tag, "_gen"}, 32'(gen), 0);
  endtask

  initial begin
    reset = 1'b1; key_nxt = 1'b0; key_run = 1'b0; rate = 8'd2;
    #1;
    chk_zero("rst_async");
    repeat (3) tick();
    chk_zero("rst_held");

    // Scan order and coordinates.
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("scan_cnt", 32'(cnt), 32'(i % 15));
      chk("scan_x", 32'(x), 32'((i % 15) % 5));
      chk("scan_y", 32'(y), 32'((i % 15) / 5));
      chk("scan_flast", 32'(frame_last), 32'((i % 15) == 14));
    end

    // Step key held 10 cycles: deb falls at cnt 1, next latch loads at cnt 14.
    wait_cnt(0);
    key_nxt = 1'b1;
    repeat (10) tick();
    chk("step_rel_cnt", 32'(cnt), 10);
    key_nxt = 1'b0;
    for (int t = 1; t <= 45; t++) begin
      tick();
      chk("step_nxt", 32'(nxt_bit), 32'(t >= 19 && t < 34));
      chk("step_gen", 32'(gen), 32'(t >= 19));
    end
    exp_gen = 1;

    // 3-cycle glitch never reaches the debounced state.
    wait_cnt(0);
    key_nxt = 1'b1;
    repeat (3) tick();
    key_nxt = 1'b0;
    for (int t = 1; t <= 35; t++) begin
      tick();
      chk("glitch_nxt", 32'(nxt_bit), 0);
    end
    chk("glitch_gen", 32'(gen), 32'(exp_gen));

    // Release lands exactly on the latch edge: served one frame later.
    wait_cnt(0);
    key_nxt = 1'b1;
    wait_cnt(8);
    key_nxt = 1'b0;
    for (int t = 1; t <= 37; t++) begin
      tick();
      chk("edge_nxt", 32'(nxt_bit), 32'(t >= 21 && t < 36));
      chk("edge_gen", 32'(gen), 32'(exp_gen + (t >= 21)));
    end
    exp_gen = 2;

    // Run mode, rate 2: auto on every third latch after the toggle latch.
    wait_cnt(0);
    key_run = 1'b1;
    wait_cnt(8);
    key_run = 1'b0;
    for (int t = 1; t <= 155; t++) begin
      tick();
      m = (t >= 6) ? (t - 6) / 15 : 0;
      chk("run_running", 32'(running), 32'(t >= 6));
      chk("run_nxt", 32'(nxt_bit), 32'(t >= 6 && m != 0 && m % 3 == 0));
      chk("run_gen", 32'(gen), 32'(exp_gen + (t >= 51) + (t >= 96) + (t >= 141)));
    end
    exp_gen = 5;

    // Second run release stops auto generation.
    wait_cnt(0);
    key_run = 1'b1;
    tick();
    wait_cnt(0);
    key_run = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      tick();
      chk("stop_running", 32'(running), 32'(t < 6));
      chk("stop_nxt", 32'(nxt_bit), 0);
    end
    chk("stop_gen", 32'(gen), 32'(exp_gen));

    // Rate 0 plus a simultaneous step: one generation per frame.
    rate = 8'd0;
    wait_cnt(0);
    key_run = 1'b1;
    key_nxt = 1'b1;
    tick();
    wait_cnt(0);
    key_run = 1'b0;
    key_nxt = 1'b0;
    for (int t = 1; t <= 74; t++) begin
      tick();
      chk("fast_running", 32'(running), 32'(t >= 6));
      chk("fast_nxt", 32'(nxt_bit), 32'(t >= 14));
      chk("fast_gen", 32'(gen), 32'(exp_gen + ((t >= 14) ? 1 + (t - 14) / 15 : 0)));
    end

    // Mid-frame reset with a pending step while running.
    wait_cnt(0);
    key_nxt = 1'b1;
    tick();
    wait_cnt(0);
    key_nxt = 1'b0;
    wait_cnt(9);
    #2 reset = 1'b1;
    #1;
    chk_zero("mid_async");
    chk("mid_flast", 32'(frame_last), 0);
    tick();
    tick();
    chk_zero("mid_held");
    reset = 1'b0;
    for (int t = 1; t <= 45; t++) begin
      tick();
      chk("post_cnt", 32'(cnt), 32'(t % 15));
      chk("post_nxt", 32'(nxt_bit), 0);
      chk("post_run", 32'(running), 0);
      chk("post_gen", 32'(gen), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
